cv32e40p_rf_recovery_ctrl: RTL and testbench
============================================

// Module: cv32e40p_rf_recovery_ctrl
// PURPOSE
//  Sequencer that restores the core register file from a backup shadow after a fault or setback.
//  Requests a core halt, then streams NUM_REGS backup entries into the RF write ports, NUM_WPORTS per cycle.
//  Drives the core recover_i / regfile_we_*/waddr_*/wdata_* inputs.
//  Generalises the fixed two-port, 32-bit recovery path: lane count, RF depth and width are parameters.
//  Adds a halt-acknowledge timeout with an error flag.
// PARAMETERS
//  NUM_WPORTS    2    RF write lanes used per restore cycle (1..4)
//  NUM_REGS      32   entries restored, starting at address 0 (64 when FPU && !PULP_ZFINX)
//  ADDR_WIDTH    6    RF address width
//  DATA_WIDTH    32   RF data width
//  SKIP_X0       1    1: lane carrying address 0 keeps its we low
//  HALT_TIMEOUT  255  max cycles in HALT waiting for core_halted_i; 0 = wait forever
// PORTS
//  clk_i          in   1                      clock
//  rst_ni         in   1                      async active-low reset
//  start_i        in   1                      recovery request, sampled in IDLE only
//  core_halted_i  in   1                      core quiescent/halted acknowledge
//  halt_req_o     out  1                      request core halt (HALT..DONE)
//  recover_o      out  1                      to core recover_i; high in RESTORE and DRAIN
//  bkp_freeze_o   out  1                      stops backup shadow capture (HALT..DONE)
//  bkp_raddr_o    out  NUM_WPORTS*ADDR_WIDTH  backup read addresses; data returns 1 cycle later
//  bkp_rdata_i    in   NUM_WPORTS*DATA_WIDTH  backup read data
//  rf_we_o        out  NUM_WPORTS             RF write enables
//  rf_waddr_o     out  NUM_WPORTS*ADDR_WIDTH  RF write addresses
//  rf_wdata_o     out  NUM_WPORTS*DATA_WIDTH  RF write data (= bkp_rdata_i, combinational)
//  busy_o         out  1                      state != IDLE
//  done_o         out  1                      1-cycle pulse in DONE
//  error_o        out  1                      sticky halt timeout; cleared by next accepted start_i
// BEHAVIOUR
//  Reset (async, rst_ni=0): state=IDLE, counters=0, lane-valid pipe=0; all outputs 0, error_o=0.
//  FSM:
//   IDLE -> HALT on start_i.
//   HALT: halt_req_o=1. core_halted_i=1 -> RESTORE next cycle.
//     Timer reaches HALT_TIMEOUT with no ack -> IDLE, error_o=1.
//   RESTORE: group g = 0..G-1, where G = ceil(NUM_REGS/NUM_WPORTS).
//     Lane l drives bkp_raddr_o[l] = g*NUM_WPORTS+l.
//     Lane valid = (addr < NUM_REGS) && !(SKIP_X0 && addr == 0); valid and address registered 1 stage.
//     After group G-1 -> DRAIN.
//   DRAIN: final registered group is written -> DONE.
//   DONE: done_o=1; halt_req_o and bkp_freeze_o still high -> IDLE. Both drop the cycle after DONE.
//  Write stage: rf_we_o[l] = registered valid[l]; rf_waddr_o[l] = registered address.
//   rf_we_o is 0 outside the cycle after each RESTORE cycle.
//  Latency: ack seen in cycle t -> first write in t+2, last write in t+G+1, done_o in t+G+2.
//  Last group partial (NUM_REGS % NUM_WPORTS != 0): lanes beyond NUM_REGS-1 keep we=0.
//    Their raddr is clamped to NUM_REGS-1.
//  core_halted_i dropping during RESTORE/DRAIN: ignored; the sequence completes.
//  start_i while busy: ignored, no queueing. start_i in DONE cycle: ignored.
//  Counters: group counter width $clog2(G+1); timer width $clog2(HALT_TIMEOUT+1); no wrap.
//  Async reset mid-sequence: immediate return to IDLE. Partial RF restore is not rolled back.
// STRUCTURE
//  cv32e40p_rf_recovery_pkg: rf_rec_state_e {IDLE,HALT,RESTORE,DRAIN,DONE}, shared
//   ceil-div/clog2 helper functions.
//  No sub-module; single FSM plus one registered lane pipeline generated per lane.
//  Elaboration assertion: 1 <= NUM_WPORTS <= 4 and NUM_REGS <= 2**ADDR_WIDTH.
// TESTING
//  1 Defaults; start_i, ack after 3 cycles
//    -> 16 write cycles; x0 we=0; lanes {1},{2,3}..{30,31}; done_o 18 cycles after ack.
//  2 HALT_TIMEOUT=4, core_halted_i held 0
//    -> IDLE after 4 HALT cycles, error_o=1, no rf_we_o.
//    Next start_i clears error_o.
//  3 NUM_WPORTS=3, NUM_REGS=32
//    -> G=11; final group lane0 writes addr 30, lane1 addr 31, lane2 we=0.
//  4 rst_ni low in RESTORE group 5
//    -> all outputs 0 the same cycle; after release, state=IDLE and busy_o=0.
//  5 start_i pulsed during RESTORE and in DONE
//    -> exactly one sequence, one done_o pulse.
//  6 SKIP_X0=0, NUM_WPORTS=1, NUM_REGS=64, bkp_rdata_i = addr^32'hA5A5A5A5
//    -> 64 writes, addr 0..63, data matches.

Source files
------------

// File: rtl/cv32e40p_rf_recovery_pkg.sv
// Shared types and elaboration-time helpers for the register-file recovery sequencer.
package cv32e40p_rf_recovery_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HALT    = 3'd1,
    RESTORE = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } rf_rec_state_e;

  // Integer ceiling division, used to size the group count.
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Smallest width (at least 1) able to encode values 0..v-1.
  function automatic int clog2_min1(input int v);
    int w;
    w = 1;
    while ((w < 31) && ((1 << w) < v)) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/cv32e40p_rf_recovery_ctrl.sv
// Register-file recovery sequencer: halts the core, then streams the backup
// shadow into the RF write ports, NUM_WPORTS entries per cycle, through a
// one-stage lane pipeline that lines addresses up with the backup read data.
module cv32e40p_rf_recovery_ctrl
  import cv32e40p_rf_recovery_pkg::*;
#(
  parameter int NUM_WPORTS   = 2,
  parameter int NUM_REGS     = 32,
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 32,
  parameter int SKIP_X0      = 1,
  parameter int HALT_TIMEOUT = 255
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             start_i,
  input  logic                             core_halted_i,
  output logic                             halt_req_o,
  output logic                             recover_o,
  output logic                             bkp_freeze_o,
  output logic [NUM_WPORTS*ADDR_WIDTH-1:0] bkp_raddr_o,
  input  logic [NUM_WPORTS*DATA_WIDTH-1:0] bkp_rdata_i,
  output logic [NUM_WPORTS-1:0]            rf_we_o,
  output logic [NUM_WPORTS*ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [NUM_WPORTS*DATA_WIDTH-1:0] rf_wdata_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             error_o
);

  localparam int NUM_GROUPS = ceil_div(NUM_REGS, NUM_WPORTS);
  localparam int GRP_W      = clog2_min1(NUM_GROUPS + 1);
  localparam int TMR_W      = clog2_min1(HALT_TIMEOUT + 1);

  localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NUM_GROUPS - 1);
  // Timer value of the final HALT cycle; meaningless when the timeout is off.
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((HALT_TIMEOUT > 0) ? HALT_TIMEOUT - 1 : 0);

  // Reject configurations the lane logic cannot address.
  if ((NUM_WPORTS < 1) || (NUM_WPORTS > 4) || (NUM_REGS < 1) ||
      (NUM_REGS > 2**ADDR_WIDTH)) begin : g_param_check
    $error("cv32e40p_rf_recovery_ctrl: NUM_WPORTS must be 1..4 and NUM_REGS <= 2**ADDR_WIDTH");
  end

  rf_rec_state_e    r_state;
  rf_rec_state_e    w_state_next;
  logic [GRP_W-1:0] r_group;
  logic [GRP_W-1:0] w_group_next;
  logic [TMR_W-1:0] r_timer;
  logic [TMR_W-1:0] w_timer_next;
  logic             r_error;
  logic             w_error_next;
  logic             w_restore;
  logic             w_timeout;

  logic [NUM_WPORTS-1:0]            w_lane_valid;
  logic [NUM_WPORTS*ADDR_WIDTH-1:0] w_lane_addr;

  assign w_restore = (r_state == RESTORE);
  assign w_timeout = (HALT_TIMEOUT > 0) && (r_timer == TMR_LAST);

  // Next-state, group counter, halt timer and sticky error.
  always_comb begin
    w_state_next = r_state;
    w_group_next = r_group;
    w_timer_next = r_timer;
    w_error_next = r_error;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_state_next = HALT;
          w_timer_next = '0;
          w_error_next = 1'b0;
        end
      end
      HALT: begin
        // An ack in the final timeout cycle still wins over the timeout.
        if (core_halted_i) begin
          w_state_next = RESTORE;
          w_group_next = '0;
        end else if (w_timeout) begin
          w_state_next = IDLE;
          w_error_next = 1'b1;
        end else if (r_timer != {TMR_W{1'b1}}) begin
          w_timer_next = r_timer + 1'b1;
        end
      end
      RESTORE: begin
        if (r_group == LAST_GRP) begin
          w_state_next = DRAIN;
          w_group_next = '0;
        end else begin
          w_group_next = r_group + 1'b1;
        end
      end
      DRAIN:   w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_group <= '0;
      r_timer <= '0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_group <= w_group_next;
      r_timer <= w_timer_next;
      r_error <= w_error_next;
    end
  end

  // One read/write lane per RF write port.
  for (genvar gi = 0; gi < NUM_WPORTS; gi++) begin : g_lane
    logic [31:0]           w_idx;
    logic                  w_in_range;
    logic                  r_lane_valid;
    logic [ADDR_WIDTH-1:0] r_lane_addr;

    assign w_idx      = 32'(r_group) * 32'(NUM_WPORTS) + 32'(gi);
    assign w_in_range = (w_idx < 32'(NUM_REGS));

    // Lanes past the end of the RF read the last entry so the backup
    // address stays legal; their write enable is suppressed anyway.
    assign w_lane_valid[gi] = w_restore && w_in_range &&
                              !((SKIP_X0 != 0) && (w_idx == 32'd0));
    assign w_lane_addr[gi*ADDR_WIDTH +: ADDR_WIDTH] =
        !w_restore ? '0 :
        w_in_range ? w_idx[ADDR_WIDTH-1:0] : ADDR_WIDTH'(NUM_REGS - 1);

    // Delay valid/address one cycle to meet the backup read latency.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_lane_valid <= 1'b0;
        r_lane_addr  <= '0;
      end else begin
        r_lane_valid <= w_lane_valid[gi];
        r_lane_addr  <= w_lane_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end

    assign rf_we_o[gi]                              = r_lane_valid;
    assign rf_waddr_o[gi*ADDR_WIDTH +: ADDR_WIDTH]  = r_lane_addr;
  end

  assign bkp_raddr_o  = w_lane_addr;
  assign rf_wdata_o   = bkp_rdata_i;
  assign busy_o       = (r_state != IDLE);
  assign halt_req_o   = (r_state != IDLE);
  assign bkp_freeze_o = (r_state != IDLE);
  assign recover_o    = (r_state == RESTORE) || (r_state == DRAIN);
  assign done_o       = (r_state == DONE);
  assign error_o      = r_error;

endmodule

// File: tb/tb_cv32e40p_rf_recovery_ctrl.sv
// Bench for the RF recovery sequencer. Four instances cover the default
// configuration, a short halt timeout, three lanes with a partial last group,
// and a single-lane 64-entry restore that includes x0.
module tb_cv32e40p_rf_recovery_ctrl;

  localparam int NI   = 4;
  localparam int AW   = 6;
  localparam int DW   = 32;
  localparam int MAXC = 80;

  function automatic int cfg_w(input int k);
    case (k)
      2:       return 3;
      3:       return 1;
      default: return 2;
    endcase
  endfunction
  function automatic int cfg_r(input int k);    return (k == 3) ? 64 : 32; endfunction
  function automatic int cfg_skip(input int k); return (k == 3) ? 0 : 1;   endfunction
  function automatic int cfg_to(input int k);   return (k == 1) ? 4 : 255; endfunction
  function automatic int cfg_g(input int k);    return (cfg_r(k) + cfg_w(k) - 1) / cfg_w(k); endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n  [NI];
  logic start  [NI];
  logic halted [NI];

  logic [3:0]    obs_we    [NI];
  logic [AW-1:0] obs_raddr [NI][4];
  logic [AW-1:0] obs_waddr [NI][4];
  logic [DW-1:0] obs_wdata [NI][4];
  logic obs_halt [NI];
  logic obs_rec  [NI];
  logic obs_frz  [NI];
  logic obs_busy [NI];
  logic obs_done [NI];
  logic obs_err  [NI];

  logic [DW-1:0] bkp_mem [64];

  // Backup shadow contents as seen by instance k.
  function automatic logic [DW-1:0] bkp_val(input int k, input int a);
    if (k == 3) return DW'(a) ^ 32'hA5A5A5A5;
    return bkp_mem[a & 63];
  endfunction

  for (genvar gk = 0; gk < NI; gk++) begin : g_inst
    localparam int W = cfg_w(gk);
    logic [W*AW-1:0] raddr;
    logic [W*DW-1:0] rdata;
    logic [W-1:0]    we;
    logic [W*AW-1:0] waddr;
    logic [W*DW-1:0] wdata;

    cv32e40p_rf_recovery_ctrl #(
      .NUM_WPORTS  (W),
      .NUM_REGS    (cfg_r(gk)),
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .SKIP_X0     (cfg_skip(gk)),
      .HALT_TIMEOUT(cfg_to(gk))
    ) u_dut (
      .clk_i        (clk),
      .rst_ni       (rst_n[gk]),
      .start_i      (start[gk]),
      .core_halted_i(halted[gk]),
      .halt_req_o   (obs_halt[gk]),
      .recover_o    (obs_rec[gk]),
      .bkp_freeze_o (obs_frz[gk]),
      .bkp_raddr_o  (raddr),
      .bkp_rdata_i  (rdata),
      .rf_we_o      (we),
      .rf_waddr_o   (waddr),
      .rf_wdata_o   (wdata),
      .busy_o       (obs_busy[gk]),
      .done_o       (obs_done[gk]),
      .error_o      (obs_err[gk])
    );

    assign obs_we[gk] = 4'(we);

    for (genvar gl = 0; gl < 4; gl++) begin : g_lane
      if (gl < W) begin : g_on
        logic [DW-1:0] rd_q;
        // Backup shadow with one-cycle read latency.
        always @(posedge clk) rd_q <= bkp_val(gk, int'(raddr[gl*AW +: AW]));
        assign rdata[gl*DW +: DW]   = rd_q;
        assign obs_raddr[gk][gl]    = raddr[gl*AW +: AW];
        assign obs_waddr[gk][gl]    = waddr[gl*AW +: AW];
        assign obs_wdata[gk][gl]    = wdata[gl*DW +: DW];
      end else begin : g_off
        assign obs_raddr[gk][gl] = '0;
        assign obs_waddr[gk][gl] = '0;
        assign obs_wdata[gk][gl] = '0;
      end
    end
  end

  typedef struct {
    int            cyc;
    int            lane;
    int            addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           got_q[$];
  logic [3:0]    cap_we    [MAXC];
  logic          cap_done  [MAXC];
  logic          cap_busy  [MAXC];
  logic          cap_halt  [MAXC];
  logic          cap_rec   [MAXC];
  logic          cap_frz   [MAXC];
  logic [AW-1:0] cap_raddr [MAXC][4];

  int n_cmp  = 0;
  int n_fail = 0;

  // Start a sequence on instance k; ack is raised after d HALT cycles and is
  // sampled at the end of the cycle in which this task returns.
  task automatic kick(input int k, input int d);
    start[k]  = 1'b1;
    halted[k] = 1'b0;
    @(negedge clk);
    start[k] = 1'b0;
    repeat (d) @(negedge clk);
    halted[k] = 1'b1;
  endtask

  // Record n cycles after the ack (index 1 = first cycle after the ack).
  // With noise_done > 0, start_i and core_halted_i toggle randomly until
  // that index, start_i is forced high in it, and low afterwards.
  task automatic capture(input int k, input int n, input int noise_done);
    got_q.delete();
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      cap_we[i]   = obs_we[k];
      cap_done[i] = obs_done[k];
      cap_busy[i] = obs_busy[k];
      cap_halt[i] = obs_halt[k];
      cap_rec[i]  = obs_rec[k];
      cap_frz[i]  = obs_frz[k];
      for (int l = 0; l < 4; l++) begin
        cap_raddr[i][l] = obs_raddr[k][l];
        if (obs_we[k][l])
          got_q.push_back(wr_t'{i, l, int'(obs_waddr[k][l]), obs_wdata[k][l]});
      end
      if (noise_done > 0) begin
        halted[k] = 1'($urandom_range(0, 1));
        if (i < noise_done)       start[k] = 1'($urandom_range(0, 1));
        else if (i == noise_done) start[k] = 1'b1;
        else                      start[k] = 1'b0;
      end else begin
        halted[k] = 1'b0;
        start[k]  = 1'b0;
      end
    end
    start[k]  = 1'b0;
    halted[k] = 1'b0;
  endtask

  task automatic fill_backup();
    for (int a = 0; a < 64; a++) bkp_mem[a] = $urandom;
  endtask

  task automatic test_reset();
    for (int k = 0; k < NI; k++) begin
      rst_n[k] = 1'b0; start[k] = 1'b0; halted[k] = 1'b0;
    end
    fill_backup();
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      n_cmp++;
      if ({obs_busy[k], obs_halt[k], obs_rec[k], obs_frz[k], obs_done[k], obs_err[k], obs_we[k],
           obs_raddr[k][0], obs_waddr[k][0]} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs k%0d: busy%b halt%b rec%b frz%b done%b err%b we%b raddr%0d waddr%0d, want all 0",
                 k, obs_busy[k], obs_halt[k], obs_rec[k], obs_frz[k], obs_done[k], obs_err[k], obs_we[k],
                 obs_raddr[k][0], obs_waddr[k][0]);
      end
      rst_n[k] = 1'b1;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      n_cmp++;
      if (obs_busy[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle k%0d: busy %b, want 0", k, obs_busy[k]);
      end
    end
  endtask

  // Full restore on instance k with ack delay d, checked against the
  // rule "address a goes to lane a%W in write cycle 2 + a/W".
  task automatic test_restore(input int k, input int d, input bit noise);
    int  w, r, g, n, done_cnt, done_at;
    wr_t exp_q[$];
    w = cfg_w(k); r = cfg_r(k); g = cfg_g(k); n = g + 5;
    @(negedge clk);
    kick(k, d);
    capture(k, n, noise ? g + 2 : 0);
    for (int a = 0; a < r; a++)
      if (!((cfg_skip(k) != 0) && (a == 0)))
        exp_q.push_back(wr_t'{2 + a / w, a % w, a, bkp_val(k, a)});
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL restore_count k%0d: %0d writes, want %0d", k, got_q.size(), exp_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
      n_cmp++;
      if (got_q[j].cyc !== exp_q[j].cyc || got_q[j].lane !== exp_q[j].lane ||
          got_q[j].addr !== exp_q[j].addr || got_q[j].data !== exp_q[j].data) begin
        n_fail++;
        $display("FAIL restore_write k%0d #%0d: cyc%0d lane%0d addr%0d data%08h, want cyc%0d lane%0d addr%0d data%08h",
                 k, j, got_q[j].cyc, got_q[j].lane, got_q[j].addr, got_q[j].data,
                 exp_q[j].cyc, exp_q[j].lane, exp_q[j].addr, exp_q[j].data);
      end
    end
    done_cnt = 0; done_at = 0;
    for (int i = 1; i <= n; i++)
      if (cap_done[i] === 1'b1) begin done_cnt++; done_at = i; end
    n_cmp++;
    if (done_cnt != 1 || done_at != g + 2) begin
      n_fail++;
      $display("FAIL restore_done k%0d: %0d pulses, last at %0d, want 1 at %0d", k, done_cnt, done_at, g + 2);
    end
    n_cmp++;
    if ({cap_rec[1], cap_rec[g + 1], cap_rec[g + 2]} !== 3'b110) begin
      n_fail++;
      $display("FAIL restore_recover k%0d: rec@1,%0d,%0d = %b%b%b, want 110",
               k, g + 1, g + 2, cap_rec[1], cap_rec[g + 1], cap_rec[g + 2]);
    end
    n_cmp++;
    if ({cap_halt[g + 2], cap_frz[g + 2], cap_halt[g + 3], cap_frz[g + 3]} !== 4'b1100) begin
      n_fail++;
      $display("FAIL restore_halt k%0d: halt/frz in DONE %b%b, after %b%b, want 11 then 00",
               k, cap_halt[g + 2], cap_frz[g + 2], cap_halt[g + 3], cap_frz[g + 3]);
    end
    n_cmp++;
    if ({cap_busy[g + 2], cap_busy[g + 3], cap_busy[g + 4], cap_busy[g + 5]} !== 4'b1000) begin
      n_fail++;
      $display("FAIL restore_busy k%0d: busy %b%b%b%b from DONE on, want 1000",
               k, cap_busy[g + 2], cap_busy[g + 3], cap_busy[g + 4], cap_busy[g + 5]);
    end
  endtask

  task automatic test_timeout();
    int g;
    g = cfg_g(1);
    @(negedge clk);
    start[1] = 1'b1; halted[1] = 1'b0;
    @(negedge clk);
    start[1] = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      n_cmp++;
      if ({obs_busy[1], obs_halt[1], obs_frz[1], obs_rec[1], obs_we[1]} !== {3'b111, 1'b0, 4'b0}) begin
        n_fail++;
        $display("FAIL timeout_halt c%0d: busy%b halt%b frz%b rec%b we%b, want 1110 we0",
                 c, obs_busy[1], obs_halt[1], obs_frz[1], obs_rec[1], obs_we[1]);
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({obs_busy[1], obs_halt[1], obs_err[1]} !== 3'b001) begin
      n_fail++;
      $display("FAIL timeout_exit: busy%b halt%b err%b, want 001", obs_busy[1], obs_halt[1], obs_err[1]);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({obs_err[1], obs_we[1]} !== 5'b10000) begin
      n_fail++;
      $display("FAIL timeout_sticky: err%b we%b, want err1 we0", obs_err[1], obs_we[1]);
    end
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    n_cmp++;
    if ({obs_err[1], obs_busy[1]} !== 2'b01) begin
      n_fail++;
      $display("FAIL timeout_clear: err%b busy%b, want err0 busy1", obs_err[1], obs_busy[1]);
    end
    halted[1] = 1'b1;
    capture(1, g + 5, 0);
    n_cmp++;
    if ({cap_done[g + 2], obs_err[1], obs_busy[1]} !== 3'b100) begin
      n_fail++;
      $display("FAIL timeout_recover: done@%0d %b err%b busy%b, want 1 0 0", g + 2, cap_done[g + 2], obs_err[1], obs_busy[1]);
    end
  endtask

  task automatic test_partial_group();
    int g;
    g = cfg_g(2);
    n_cmp++;
    if (g != 11) begin
      n_fail++;
      $display("FAIL partial_groups: G %0d, want 11", g);
    end
    @(negedge clk);
    kick(2, 1);
    capture(2, g + 5, 0);
    n_cmp++;
    if (cap_we[g + 1] !== 4'b0011) begin
      n_fail++;
      $display("FAIL partial_we: last write we %b, want 0011", cap_we[g + 1]);
    end
    n_cmp++;
    if ({cap_raddr[g][0], cap_raddr[g][1], cap_raddr[g][2]} !== {6'd30, 6'd31, 6'd31}) begin
      n_fail++;
      $display("FAIL partial_raddr: last group raddr %0d %0d %0d, want 30 31 31",
               cap_raddr[g][0], cap_raddr[g][1], cap_raddr[g][2]);
    end
    n_cmp++;
    if (got_q.size() < 2) begin
      n_fail++;
      $display("FAIL partial_tail: %0d writes, want 31", got_q.size());
    end else if (got_q[got_q.size() - 2].addr != 30 || got_q[got_q.size() - 2].lane != 0 ||
                 got_q[got_q.size() - 1].addr != 31 || got_q[got_q.size() - 1].lane != 1) begin
      n_fail++;
      $display("FAIL partial_tail: lane%0d addr%0d, lane%0d addr%0d, want lane0 addr30, lane1 addr31",
               got_q[got_q.size() - 2].lane, got_q[got_q.size() - 2].addr,
               got_q[got_q.size() - 1].lane, got_q[got_q.size() - 1].addr);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    kick(0, 0);
    capture(0, 6, 0);
    n_cmp++;
    if ({cap_raddr[6][0], cap_raddr[6][1], cap_we[6]} !== {6'd10, 6'd11, 4'b0011}) begin
      n_fail++;
      $display("FAIL areset_group5: raddr %0d %0d we %b, want 10 11 0011", cap_raddr[6][0], cap_raddr[6][1], cap_we[6]);
    end
    #1 rst_n[0] = 1'b0;
    #1;
    n_cmp++;
    if ({obs_busy[0], obs_halt[0], obs_rec[0], obs_frz[0], obs_done[0], obs_err[0], obs_we[0],
         obs_raddr[0][0], obs_raddr[0][1], obs_waddr[0][0], obs_waddr[0][1]} !== '0) begin
      n_fail++;
      $display("FAIL areset_outputs: busy%b halt%b rec%b frz%b done%b err%b we%b raddr %0d %0d waddr %0d %0d, want all 0",
               obs_busy[0], obs_halt[0], obs_rec[0], obs_frz[0], obs_done[0], obs_err[0], obs_we[0],
               obs_raddr[0][0], obs_raddr[0][1], obs_waddr[0][0], obs_waddr[0][1]);
    end
    @(negedge clk);
    rst_n[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if ({obs_busy[0], obs_we[0], obs_rec[0]} !== 6'b0) begin
        n_fail++;
        $display("FAIL areset_idle: busy%b we%b rec%b, want 0", obs_busy[0], obs_we[0], obs_rec[0]);
      end
    end
  endtask

  task automatic test_start_ignored();
    test_restore(0, 2, 1'b1);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (obs_busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL start_ignored_idle: busy %b, want 0", obs_busy[0]);
    end
  endtask

  task automatic test_noskip();
    test_restore(3, 1, 1'b0);
    n_cmp++;
    if (got_q.size() != 64) begin
      n_fail++;
      $display("FAIL noskip_count: %0d writes, want 64", got_q.size());
    end else if (got_q[0].addr != 0 || got_q[0].data !== 32'hA5A5A5A5 ||
                 got_q[63].addr != 63 || got_q[63].data !== 32'hA5A5A59A) begin
      n_fail++;
      $display("FAIL noskip_ends: first addr%0d data%08h last addr%0d data%08h, want 0 A5A5A5A5 63 A5A5A59A",
               got_q[0].addr, got_q[0].data, got_q[63].addr, got_q[63].data);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    for (int t = 0; t < 4; t++) begin
      fill_backup();
      case ($urandom_range(0, 2))
        0:       k = 0;
        1:       k = 2;
        default: k = 3;
      endcase
      test_restore(k, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_restore(0, 3, 1'b0);
    test_timeout();
    test_partial_group();
    test_async_reset();
    test_start_ignored();
    test_noskip();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
